npu_cmd_scheduler: RTL and testbench
====================================

# npu_cmd_scheduler

Sequences custom (NPU) instructions from the softcore's EXECUTE stage onto the single-outstanding NPU command port and returns each result to the register-file writeback path. It provides a small command queue, so the core stalls only when the queue is full. It sits between the core pipeline and `npu_top`, replacing the direct one-cycle `npu_start` pulse with a proper valid/ready handshake.

## Interface
- `DEPTH`, 4: command queue entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 1024: result watchdog limit in cycles; used only with `NPU_SCHED_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `cmd_valid`  in  1  core offers an NPU instruction.
- `cmd_ready`  out  1  queue not full.
- `cmd_instr`  in  32  raw custom instruction.
- `cmd_rd`  in  5  destination register tag.
- `flush`  in  1  drop all queued, not-yet-issued commands.
- `npu_cmd_valid`  out  1  command presented to NPU.
- `npu_cmd_ready`  in  1  NPU accepts command.
- `npu_cmd_data`  out  32  instruction to NPU.
- `npu_result`  in  32  NPU result.
- `npu_result_valid`  in  1  result strobe; single cycle.
- `wb_valid`  out  1  result ready for register file.
- `wb_ready`  in  1  writeback port free.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  result value.
- `busy`  out  1  state ≠ IDLE or queue non-empty.
- `err_timeout`  out  1  sticky watchdog error (0 without the macro).

## Operation
- Queue: FIFO of {instr, rd}. Push on `cmd_valid && cmd_ready`. `cmd_ready = !full`. A push is never accepted while full, even if a pop happens in the same cycle.
- FSM states: IDLE, ISSUE, WAIT_RES, WB.
- IDLE: if queue non-empty, pop the head into hold registers (`hold_instr`, `hold_rd`) → ISSUE.
- ISSUE: `npu_cmd_valid = 1`, `npu_cmd_data = hold_instr`. Both stay stable until `npu_cmd_ready`. On the handshake → WAIT_RES.
- WAIT_RES: on `npu_result_valid`, capture `npu_result`.
  - If `hold_rd ≠ 0` → WB.
  - If `hold_rd == 0`, discard the result; go to ISSUE with the next head popped if the queue is non-empty, else IDLE.
- WB: `wb_valid = 1`, `wb_rd = hold_rd`, `wb_data` = captured result; stable until `wb_ready`. On the handshake, pop the next head → ISSUE if the queue is non-empty, else → IDLE.
- `npu_result_valid` outside WAIT_RES is ignored.
- `flush`: clears the FIFO pointers and count in one cycle. It does not affect the command held in ISSUE/WAIT_RES/WB, which completes normally.
  - flush and push in the same cycle: flush wins and the push is dropped. `cmd_ready` is still 1, so the core must not assert `cmd_valid` with `flush`.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Only one command is outstanding at the NPU; results are returned in issue order.

## Timing
- Reset values: `cmd_ready = 1`, `err_timeout = 0`, all other outputs 0. Reset leaves the FSM in IDLE with the queue empty.
- Reset asserted mid-operation abandons the in-flight command without writeback.
- Push at edge N into an empty, idle block → `npu_cmd_valid` high in cycle N+1.
- `npu_result_valid` in cycle M → `wb_valid` high in cycle M+1.
- Back-to-back commands: `wb_ready` handshake at cycle K → next `npu_cmd_valid` in cycle K+1 (no IDLE bubble).
- `busy` is registered-state derived: combinational from state and count, with no extra latency.

## Configuration
- `NPU_SCHED_TIMEOUT_EN` defined:
  - A counter runs in WAIT_RES and clears on entry.
  - When it reaches `TIMEOUT_CYCLES` with no result, `err_timeout` is set (sticky until `flush` or reset), the command is dropped without writeback, and the FSM → IDLE.
- Undefined: no counter; WAIT_RES waits indefinitely; `err_timeout` is tied to 0.

## Structure
- Package `npu_sched_pkg`: FSM state enum (`SCHED_IDLE`, `SCHED_ISSUE`, `SCHED_WAIT_RES`, `SCHED_WB`), `NPU_INSTR_W = 32`, `REG_TAG_W = 5`.
- Sub-module `npu_cmd_fifo`: synchronous FIFO with parameterised depth, providing push/pop/flush, full/empty and count outputs.

## Test plan
- Single command: push instr 0x0000_100B, rd = 3; NPU ready immediately; result 0xDEAD_BEEF two cycles later → `npu_cmd_valid` in cycle 1; `wb_valid` with rd = 3, data 0xDEAD_BEEF one cycle after the result; `busy` low afterwards.
- Fill queue: push 5 commands with DEPTH = 4 and NPU ready held 0 → 4 queued plus 1 in hold; `cmd_ready` low; when NPU ready rises, commands issue in order.
- rd = 0: command with rd = 0, result 0x1234 → no `wb_valid`; next queued command issues one cycle after the result.
- Backpressure: `wb_ready = 0` for 10 cycles → `wb_valid`, `wb_rd`, `wb_data` stable; `npu_cmd_valid` stays low until the writeback handshake.
- Flush: 3 queued and 1 in WAIT_RES, pulse `flush` → queue empty, `cmd_ready = 1`; the in-flight result is still written back; no further issues.
- Timeout (macro on, TIMEOUT_CYCLES = 16): no result → `err_timeout` rises 16 cycles after entering WAIT_RES, no writeback, FSM returns to IDLE; `flush` clears `err_timeout`.

Source files
------------

// File: rtl/npu_sched_pkg.sv
// Shared types for the NPU command scheduler.
// FSM state enum, queued command bundle and field widths.
package npu_sched_pkg;

  localparam int NPU_INSTR_W = 32;
  localparam int REG_TAG_W   = 5;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_ISSUE,
    SCHED_WAIT_RES,
    SCHED_WB
  } sched_state_e;

  typedef struct packed {
    logic [NPU_INSTR_W-1:0] instr;
    logic [REG_TAG_W-1:0]   rd;
  } sched_cmd_t;

endpackage

// File: rtl/npu_cmd_fifo.sv
// Synchronous command FIFO; pushes are dropped when full or on flush.
// Ports: clk, rst_n, i_push/i_pop/i_flush, i_wdata, o_rdata (head), o_full, o_empty, o_count.
module npu_cmd_fifo
  import npu_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  sched_cmd_t               i_wdata,
  output sched_cmd_t               o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  sched_cmd_t          r_mem [DEPTH];
  logic [AW-1:0]       r_wr;
  logic [AW-1:0]       r_rd;
  logic [AW:0]         r_count;
  logic                w_push;
  logic                w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd];

  // full blocks a push even if a pop frees a slot this cycle
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_wdata;
  end

endmodule

// File: rtl/npu_cmd_scheduler.sv
// Queues core NPU instructions, issues one at a time to the NPU, returns results to writeback.
// Ports: cmd_* (core side), flush, npu_cmd_* / npu_result* (NPU side), wb_* (regfile), busy, err_timeout.
// Optional macro NPU_SCHED_TIMEOUT_EN enables the WAIT_RES result watchdog.
module npu_cmd_scheduler
  import npu_sched_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [NPU_INSTR_W-1:0] cmd_instr,
  input  logic [REG_TAG_W-1:0]   cmd_rd,
  input  logic                   flush,
  output logic                   npu_cmd_valid,
  input  logic                   npu_cmd_ready,
  output logic [NPU_INSTR_W-1:0] npu_cmd_data,
  input  logic [NPU_INSTR_W-1:0] npu_result,
  input  logic                   npu_result_valid,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [REG_TAG_W-1:0]   wb_rd,
  output logic [NPU_INSTR_W-1:0] wb_data,
  output logic                   busy,
  output logic                   err_timeout
);

  sched_state_e           r_state;
  sched_state_e           w_state_nxt;
  sched_cmd_t             w_push_cmd;
  sched_cmd_t             w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_pop;
  logic                   w_avail;
  logic                   w_timeout;
  logic [NPU_INSTR_W-1:0] r_hold_instr;
  logic [REG_TAG_W-1:0]   r_hold_rd;
  logic [NPU_INSTR_W-1:0] r_res;

  assign w_push_cmd = '{instr: cmd_instr, rd: cmd_rd};

  npu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cmd_valid),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_wdata (w_push_cmd),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // a flushing queue must not hand its head to the hold registers
  assign w_avail = !w_empty && !flush;

  assign cmd_ready     = !w_full;
  assign npu_cmd_valid = (r_state == SCHED_ISSUE);
  assign npu_cmd_data  = r_hold_instr;
  assign wb_valid      = (r_state == SCHED_WB);
  assign wb_rd         = r_hold_rd;
  assign wb_data       = r_res;
  assign busy          = (r_state != SCHED_IDLE) || (w_count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= SCHED_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      SCHED_IDLE: begin
        if (w_avail) begin
          w_pop       = 1'b1;
          w_state_nxt = SCHED_ISSUE;
        end
      end
      SCHED_ISSUE: begin
        if (npu_cmd_ready) w_state_nxt = SCHED_WAIT_RES;
      end
      SCHED_WAIT_RES: begin
        if (w_timeout) begin
          w_state_nxt = SCHED_IDLE;
        end else if (npu_result_valid) begin
          if (r_hold_rd != '0) begin
            w_state_nxt = SCHED_WB;
          end else if (w_avail) begin
            w_pop       = 1'b1;
            w_state_nxt = SCHED_ISSUE;
          end else begin
            w_state_nxt = SCHED_IDLE;
          end
        end
      end
      SCHED_WB: begin
        if (wb_ready) begin
          if (w_avail) begin
            w_pop       = 1'b1;
            w_state_nxt = SCHED_ISSUE;
          end else begin
            w_state_nxt = SCHED_IDLE;
          end
        end
      end
      default: w_state_nxt = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_instr <= '0;
      r_hold_rd    <= '0;
      r_res        <= '0;
    end else begin
      if (w_pop) begin
        r_hold_instr <= w_head.instr;
        r_hold_rd    <= w_head.rd;
      end
      if (r_state == SCHED_WAIT_RES && npu_result_valid) begin
        r_res <= npu_result;
      end
    end
  end

`ifdef NPU_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  // counter value k means k full cycles already spent in WAIT_RES
  assign w_timeout   = (r_state == SCHED_WAIT_RES) && !npu_result_valid &&
                       (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == SCHED_WAIT_RES) r_to_cnt <= r_to_cnt + 1'b1;
      else                           r_to_cnt <= '0;
      if (w_timeout)  r_err <= 1'b1;
      else if (flush) r_err <= 1'b0;
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_npu_cmd_scheduler.sv
// Directed self-checking bench for npu_cmd_scheduler.
// One task per scenario; inputs driven and outputs sampled 1ns after rising edges.
module tb_npu_cmd_scheduler;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_instr;
  logic [4:0]  cmd_rd;
  logic        flush;
  logic        npu_cmd_valid;
  logic        npu_cmd_ready;
  logic [31:0] npu_cmd_data;
  logic [31:0] npu_result;
  logic        npu_result_valid;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic        err_timeout;

  int checks;
  int failures;

  npu_cmd_scheduler #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_instr        (cmd_instr),
    .cmd_rd           (cmd_rd),
    .flush            (flush),
    .npu_cmd_valid    (npu_cmd_valid),
    .npu_cmd_ready    (npu_cmd_ready),
    .npu_cmd_data     (npu_cmd_data),
    .npu_result       (npu_result),
    .npu_result_valid (npu_result_valid),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .busy             (busy),
    .err_timeout      (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [4:0] rd);
    cmd_valid = 1'b1;
    cmd_instr = ins;
    cmd_rd    = rd;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic result(input logic [31:0] val);
    npu_result_valid = 1'b1;
    npu_result       = val;
    tick();
    npu_result_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
    end
    checks++;
    if (npu_cmd_valid !== 1'b0) begin
      failures++; $display("FAIL reset_npu_valid got=%b exp=0", npu_cmd_valid);
    end
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++; $display("FAIL reset_err got=%b exp=0", err_timeout);
    end
    checks++;
    if ({npu_cmd_data, wb_rd, wb_data} !== 69'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", npu_cmd_data, wb_rd, wb_data);
    end
  endtask

  task automatic test_single();
    npu_cmd_ready = 1'b1;
    wb_ready      = 1'b1;
    push(32'h0000_100B, 5'd3);
    checks++;
    if (busy !== 1'b1 || npu_cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_queued got busy=%b nv=%b exp busy=1 nv=0", busy, npu_cmd_valid);
    end
    tick();
    checks++;
    if (npu_cmd_valid !== 1'b1 || npu_cmd_data !== 32'h0000_100B) begin
      failures++;
      $display("FAIL single_issue got v=%b d=%h exp v=1 d=0000100b", npu_cmd_valid, npu_cmd_data);
    end
    tick();
    checks++;
    if (npu_cmd_valid !== 1'b0) begin
      failures++; $display("FAIL single_issue_drop got=%b exp=0", npu_cmd_valid);
    end
    tick();
    result(32'hDEAD_BEEF);
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_wb got v=%b rd=%0d d=%h exp v=1 rd=3 d=deadbeef", wb_valid, wb_rd, wb_data);
    end
    tick();
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done got wb=%b busy=%b exp 0 0", wb_valid, busy);
    end
  endtask

  task automatic test_fill();
    npu_cmd_ready = 1'b0;
    wb_ready      = 1'b1;
    for (int i = 0; i < 5; i++) push(32'h0000_200B + 32'(i), 5'(i + 1));
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++; $display("FAIL fill_full got=%b exp=0", cmd_ready);
    end
    // attempt while full: must be dropped
    push(32'h0000_0BAD, 5'd20);
    checks++;
    if (npu_cmd_valid !== 1'b1 || npu_cmd_data !== 32'h0000_200B) begin
      failures++;
      $display("FAIL fill_hold got v=%b d=%h exp v=1 d=0000200b", npu_cmd_valid, npu_cmd_data);
    end
    npu_cmd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (npu_cmd_valid !== 1'b1 || npu_cmd_data !== 32'h0000_200B + 32'(k)) begin
        failures++;
        $display("FAIL fill_order%0d got v=%b d=%h exp v=1 d=%h", k, npu_cmd_valid, npu_cmd_data, 32'h0000_200B + 32'(k));
      end
      tick();
      result(32'hA000 + 32'(k));
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'(k + 1) || wb_data !== 32'hA000 + 32'(k)) begin
        failures++;
        $display("FAIL fill_wb%0d got v=%b rd=%0d d=%h exp rd=%0d", k, wb_valid, wb_rd, wb_data, k + 1);
      end
      tick();
      if (k < 4) begin
        checks++;
        if (npu_cmd_valid !== 1'b1) begin
          failures++; $display("FAIL back_to_back%0d got=%b exp=1", k, npu_cmd_valid);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_drained got busy=%b rdy=%b exp 0 1", busy, cmd_ready);
    end
  endtask

  task automatic test_rd0();
    npu_cmd_ready = 1'b1;
    wb_ready      = 1'b1;
    push(32'h0000_300B, 5'd0);
    push(32'h0000_310B, 5'd7);
    tick();
    result(32'h0000_1234);
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++; $display("FAIL rd0_no_wb got=%b exp=0", wb_valid);
    end
    checks++;
    if (npu_cmd_valid !== 1'b1 || npu_cmd_data !== 32'h0000_310B) begin
      failures++;
      $display("FAIL rd0_next got v=%b d=%h exp v=1 d=0000310b", npu_cmd_valid, npu_cmd_data);
    end
    tick();
    result(32'h0000_5555);
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h0000_5555) begin
      failures++;
      $display("FAIL rd0_second got v=%b rd=%0d d=%h exp v=1 rd=7 d=5555", wb_valid, wb_rd, wb_data);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rd0_done got=%b exp=0", busy);
    end
  endtask

  task automatic test_backpressure();
    npu_cmd_ready = 1'b1;
    wb_ready      = 1'b0;
    push(32'h0000_400B, 5'd9);
    push(32'h0000_410B, 5'd10);
    tick();
    result(32'hCAFE_0001);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'hCAFE_0001 || npu_cmd_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_stable%0d got v=%b rd=%0d d=%h nv=%b exp v=1 rd=9 d=cafe0001 nv=0", i, wb_valid, wb_rd, wb_data, npu_cmd_valid);
      end
      // a stray strobe outside WAIT_RES must not touch the result
      if (i == 3) result(32'hFFFF_FFFF);
      else tick();
    end
    wb_ready = 1'b1;
    tick();
    checks++;
    if (npu_cmd_valid !== 1'b1 || npu_cmd_data !== 32'h0000_410B) begin
      failures++;
      $display("FAIL bp_next got v=%b d=%h exp v=1 d=0000410b", npu_cmd_valid, npu_cmd_data);
    end
    tick();
    result(32'h0000_0002);
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL bp_done got=%b exp=0", busy);
    end
  endtask

  task automatic test_flush();
    npu_cmd_ready = 1'b1;
    wb_ready      = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h0000_500B + 32'(i), 5'(11 + i));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b1 || npu_cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_state got rdy=%b busy=%b nv=%b exp 1 1 0", cmd_ready, busy, npu_cmd_valid);
    end
    result(32'h0F0F_0F0F);
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd11 || wb_data !== 32'h0F0F_0F0F) begin
      failures++;
      $display("FAIL flush_inflight got v=%b rd=%0d d=%h exp v=1 rd=11 d=0f0f0f0f", wb_valid, wb_rd, wb_data);
    end
    tick();
    tick();
    tick();
    checks++;
    if (npu_cmd_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_issue got nv=%b busy=%b exp 0 0", npu_cmd_valid, busy);
    end
    cmd_valid = 1'b1;
    cmd_instr = 32'h0000_0F0B;
    cmd_rd    = 5'd1;
    flush     = 1'b1;
    tick();
    cmd_valid = 1'b0;
    flush     = 1'b0;
    tick();
    checks++;
    if (npu_cmd_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_push got nv=%b busy=%b exp 0 0", npu_cmd_valid, busy);
    end
  endtask

  task automatic test_reset_midop();
    npu_cmd_ready = 1'b1;
    wb_ready      = 1'b1;
    push(32'h0000_600B, 5'd4);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    result(32'h0000_7777);
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_midop got wb=%b busy=%b exp 0 0", wb_valid, busy);
    end
  endtask

  task automatic test_timeout();
    npu_cmd_ready = 1'b1;
    wb_ready      = 1'b1;
    push(32'h0000_700B, 5'd2);
    tick();
    tick();
`ifdef NPU_SCHED_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early got err=%b busy=%b exp 0 1", err_timeout, busy);
    end
    tick();
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire got err=%b busy=%b wb=%b exp 1 0 0", err_timeout, busy, wb_valid);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++; $display("FAIL timeout_clear got=%b exp=0", err_timeout);
    end
`else
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL no_timeout got err=%b busy=%b exp 0 1", err_timeout, busy);
    end
    result(32'h0000_00AA);
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'h0000_00AA) begin
      failures++;
      $display("FAIL late_result got v=%b rd=%0d d=%h exp v=1 rd=2 d=aa", wb_valid, wb_rd, wb_data);
    end
    tick();
`endif
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst_n            = 1'b0;
    cmd_valid        = 1'b0;
    cmd_instr        = '0;
    cmd_rd           = '0;
    flush            = 1'b0;
    npu_cmd_ready    = 1'b0;
    npu_result       = '0;
    npu_result_valid = 1'b0;
    wb_ready         = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_rd0();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
